// File: rtl/cic_pkg.sv
// Shared definitions for the CIC conversion controller: FSM state encoding
// and default sizing constants.
package cic_pkg;

  localparam int CIC_DATA_W = 14;
  localparam int CIC_SETTLE = 3;
  localparam int AVG_LEN    = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_HOLD    = 3'd4
  } cic_state_t;

endpackage

// File: rtl/cic_sample_cnt.sv
// Down-counter of cic_valid strobes. tc is high while one strobe remains, so
// the FSM sees the terminal strobe as (en && tc). It is used for both the
// settle count and the per-result sample count.
module cic_sample_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Clear beats load, and load beats decrement. The count saturates at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(1));

endmodule

// File: rtl/cic_conv_ctrl.sv
// CIC decimator conversion sequencer: enables the modulator, clears the
// filter, discards settling outputs, then hands results out over a
// valid/ready port. This supports single-shot and continuous modes.
// Optional build macro CIC_CTRL_AVG_EN makes each result the average of
// AVG_LEN samples. The default build uses one sample per result.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | modulator off, waiting for start
// ST_CLEAR   | one-cycle cic_clr pulse to the filter
// ST_SETTLE  | discarding SETTLE_SAMPLES filter outputs
// ST_CONVERT | collecting samples for the next result
// ST_HOLD    | result presented, waiting for res_ready
module cic_conv_ctrl
  import cic_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = CIC_DATA_W,
  parameter int SETTLE_SAMPLES = CIC_SETTLE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cont,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  input  logic                      cic_valid,
  input  logic [DATA_W-1:0]         cic_data,
  output logic                      mod_en,
  output logic [$clog2(NUM_CH)-1:0] ch_mux,
  output logic                      cic_clr,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic                      busy,
  output logic                      overrun
);

`ifdef CIC_CTRL_AVG_EN
  localparam int SPR = AVG_LEN;
`else
  localparam int SPR = 1;
`endif
  localparam int CNT_MAX = (SETTLE_SAMPLES > SPR) ? SETTLE_SAMPLES : SPR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  cic_state_t        state;
  logic              mode_cont;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_en;
  logic              cnt_tc;
  logic              hs;
  logic [DATA_W-1:0] result;

  assign hs     = res_valid && res_ready;
  assign busy   = (state != ST_IDLE);
  assign cnt_en = cic_valid && ((state == ST_SETTLE) || (state == ST_CONVERT));

  // A strobe that arrives in the same cycle as a continuous-mode handshake
  // counts as the first sample of the next result.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = CNT_W'(SETTLE_SAMPLES);
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SETTLE_SAMPLES);
        end
      end
      ST_SETTLE: begin
        if (cic_valid && cnt_tc) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SPR);
        end
      end
      ST_HOLD: begin
        if (hs && mode_cont) begin
          cnt_load = 1'b1;
          cnt_val  = cic_valid ? CNT_W'(SPR - 1) : CNT_W'(SPR);
        end
      end
      default: ;
    endcase
  end

  cic_sample_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (abort),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

`ifdef CIC_CTRL_AVG_EN
  logic [DATA_W+1:0] acc;
  logic [DATA_W+1:0] acc_sum;

  assign acc_sum = acc + {2'b00, cic_data};
  assign result  = acc_sum[DATA_W+1:2];

  // Sum the samples of one result. The accumulator restarts after each
  // result, and it can be seeded by a strobe that arrives with the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (abort || (state == ST_IDLE)) begin
      acc <= '0;
    end else if ((state == ST_CONVERT) && cic_valid) begin
      acc <= cnt_tc ? '0 : acc_sum;
    end else if ((state == ST_HOLD) && hs && mode_cont && cic_valid) begin
      acc <= {2'b00, cic_data};
    end
  end
`else
  assign result = cic_data;
`endif

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mode_cont <= 1'b0;
      mod_en    <= 1'b0;
      cic_clr   <= 1'b0;
      ch_mux    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ch    <= '0;
      overrun   <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      mod_en    <= 1'b0;
      cic_clr   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_CLEAR;
            ch_mux    <= ch_sel;
            mode_cont <= cont;
            overrun   <= 1'b0;
            cic_clr   <= 1'b1;
            mod_en    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cic_clr <= 1'b0;
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cic_valid && cnt_tc) begin
            state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (cic_valid && cnt_tc) begin
            res_data  <= result;
            res_ch    <= ch_mux;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hs) begin
            if (!mode_cont) begin
              res_valid <= 1'b0;
              mod_en    <= 1'b0;
              state     <= ST_IDLE;
            end else if (cic_valid && (SPR == 1)) begin
              res_data <= result;
              res_ch   <= ch_mux;
            end else begin
              res_valid <= 1'b0;
              state     <= ST_CONVERT;
            end
          end else if (cic_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mod_en    <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_conv_ctrl.sv
// Directed bench for cic_conv_ctrl in the default build (one sample per result).
module tb_cic_conv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        cont;
  logic [1:0]  ch_sel;
  logic        cic_valid;
  logic [13:0] cic_data;
  logic        mod_en;
  logic [1:0]  ch_mux;
  logic        cic_clr;
  logic        res_valid;
  logic        res_ready;
  logic [13:0] res_data;
  logic [1:0]  res_ch;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int clr_pulses = 0;
  int valid_seen = 0;

  cic_conv_ctrl #(.NUM_CH(4), .DATA_W(14), .SETTLE_SAMPLES(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .cont      (cont),
    .ch_sel    (ch_sel),
    .cic_valid (cic_valid),
    .cic_data  (cic_data),
    .mod_en    (mod_en),
    .ch_mux    (ch_mux),
    .cic_clr   (cic_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ch    (res_ch),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cic_clr) clr_pulses++;
    if (res_valid) valid_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [13:0] d);
    cic_data  = d;
    cic_valid = 1'b1;
    step();
    cic_valid = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] ch, input logic c);
    ch_sel = ch;
    cont   = c;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 0; abort = 0; cont = 0; ch_sel = 0;
    cic_valid = 0; cic_data = 0; res_ready = 0;
    step(3);
    chk("rst_mod_en", mod_en, 0);
    chk("rst_cic_clr", cic_clr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ch_mux", ch_mux, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ch", res_ch, 0);
    reset_n = 1'b1;
    step(2);

    // Single-shot conversion on channel 2.
    res_ready = 1'b1;
    clr_pulses = 0;
    do_start(2'd2, 1'b0);
    chk("ss_clear_pulse", cic_clr, 1);
    chk("ss_clear_mod_en", mod_en, 1);
    chk("ss_ch_mux", ch_mux, 2);
    step();
    chk("ss_clr_one_cycle", cic_clr, 0);
    for (int k = 0; k < 3; k++) begin
      strobe(14'h1234);
      step(2);
      chk("ss_settle_no_valid", res_valid, 0);
    end
    chk("ss_busy_settled", busy, 1);
    strobe(14'h1234);
    chk("ss_res_valid", res_valid, 1);
    chk("ss_res_data", res_data, 14'h1234);
    chk("ss_res_ch", res_ch, 2);
    step();
    chk("ss_done_valid", res_valid, 0);
    chk("ss_done_mod_en", mod_en, 0);
    chk("ss_done_busy", busy, 0);
    chk("ss_clr_pulse_count", clr_pulses, 1);

    // Continuous mode with a stalled consumer, which sets overrun.
    res_ready = 1'b0;
    do_start(2'd1, 1'b1);
    step();
    for (int k = 0; k < 3; k++) strobe(14'h0111);
    strobe(14'h0AAA);
    chk("ov_first_valid", res_valid, 1);
    chk("ov_first_data", res_data, 14'h0AAA);
    chk("ov_no_overrun_yet", overrun, 0);
    for (int k = 0; k < 600; k++) begin
      cic_data  = 14'h0555;
      cic_valid = ((k % 256) == 255);
      step();
    end
    cic_valid = 1'b0;
    chk("ov_overrun", overrun, 1);
    chk("ov_valid_held", res_valid, 1);
    chk("ov_data_held", res_data, 14'h0AAA);
    chk("ov_ch_held", res_ch, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("ov_back_convert_valid", res_valid, 0);
    chk("ov_back_convert_mod_en", mod_en, 1);
    strobe(14'h0555);
    chk("ov_next_valid", res_valid, 1);
    chk("ov_next_data", res_data, 14'h0555);
    chk("ov_overrun_sticky", overrun, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ov_abort_idle", busy, 0);
    chk("ov_abort_valid", res_valid, 0);
    do_start(2'd0, 1'b1);
    chk("ov_start_clears", overrun, 0);

    // Strobe in the same cycle as a continuous-mode handshake.
    step();
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) strobe(14'h0050);
    strobe(14'h0100);
    chk("hs_first_data", res_data, 14'h0100);
    strobe(14'h0200);
    chk("hs_same_cycle_valid", res_valid, 1);
    chk("hs_same_cycle_data", res_data, 14'h0200);
    chk("hs_same_cycle_no_ovr", overrun, 0);
    step();
    chk("hs_to_convert", res_valid, 0);
    chk("hs_busy", busy, 1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    chk("hs_abort_beats_start", busy, 0);
    start = 1'b0;
    chk("hs_abort_mod_en", mod_en, 0);

    // Abort during settle after two strobes.
    res_ready = 1'b1;
    do_start(2'd3, 1'b0);
    step();
    strobe(14'h0001);
    strobe(14'h0002);
    chk("ab_still_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_mod_en", mod_en, 0);
    valid_seen = 0;
    for (int k = 0; k < 5; k++) strobe(14'h0003);
    chk("ab_no_result", valid_seen, 0);

    // Start during conversion is ignored.
    res_ready = 1'b0;
    do_start(2'd2, 1'b0);
    step();
    for (int k = 0; k < 3; k++) strobe(14'h0010);
    ch_sel = 2'd3;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("ig_ch_mux", ch_mux, 2);
    chk("ig_busy", busy, 1);
    strobe(14'h0ABC);
    chk("ig_res_ch", res_ch, 2);
    chk("ig_res_data", res_data, 14'h0ABC);

    // Asynchronous reset while holding a result.
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_res_valid", res_valid, 0);
    chk("ar_mod_en", mod_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_res_data", res_data, 0);
    chk("ar_ch_mux", ch_mux, 0);
    step(2);
    reset_n = 1'b1;
    step();
    valid_seen = 0;
    for (int k = 0; k < 6; k++) strobe(14'h0777);
    chk("ar_no_result", valid_seen, 0);
    chk("ar_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_conv_ctrl.md
CIC_CONV_CTRL -- requirements
Module: cic_conv_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of modulator input channels.
REQ-002 SHALL have parameter DATA_W, default 14, filter output and result width.
REQ-003 SHALL have parameter SETTLE_SAMPLES, default 3, filter outputs discarded after clear.
REQ-004 SHALL have port clk, input, 1, high-speed modulator clock; the only clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous digital reset, active low.
REQ-006 SHALL have port start, input, 1, conversion request pulse.
REQ-007 SHALL have port abort, input, 1, terminate any activity.
REQ-008 SHALL have port cont, input, 1, continuous-conversion mode, sampled with start.
REQ-009 SHALL have port ch_sel, input, $clog2(NUM_CH), requested channel, sampled with start.
REQ-010 SHALL have port cic_valid, input, 1, one-cycle strobe: new filter output present.
REQ-011 SHALL have port cic_data, input, DATA_W, unsigned filter output.
REQ-012 SHALL have port mod_en, output, 1, modulator enable.
REQ-013 SHALL have port ch_mux, output, $clog2(NUM_CH), analog channel select.
REQ-014 SHALL have port cic_clr, output, 1, synchronous clear to filter and decimation counter.
REQ-015 SHALL have ports res_valid/res_ready (output/input, 1), res_data (output, DATA_W), res_ch (output, $clog2(NUM_CH)).
REQ-016 SHALL have ports busy (output, 1, state != IDLE) and overrun (output, 1, sticky).

Function
REQ-017 SHALL implement FSM IDLE, CLEAR, SETTLE, CONVERT, HOLD.
REQ-018 IDLE: start=1 latches ch_sel into ch_mux and cont into internal mode, clears overrun, goes to CLEAR next cycle.
REQ-019 CLEAR: exactly one cycle, cic_clr=1, mod_en=1; then SETTLE.
REQ-020 SETTLE: counts cic_valid strobes; the SETTLE_SAMPLES-th strobe moves to CONVERT; samples discarded.
REQ-021 CONVERT: each cic_valid captures cic_data; when the result is complete, res_data/res_ch are registered, res_valid=1 next cycle, state HOLD.
REQ-022 HOLD: res_valid, res_data, res_ch stable until res_valid&&res_ready.
REQ-023 On handshake with cont=1: return to CONVERT without re-clear or re-settle; with cont=0: IDLE, mod_en=0.
REQ-024 cic_valid in HOLD: sample dropped, overrun=1 until next accepted start.
REQ-025 cic_valid and handshake in the same HOLD cycle: sample counted as first CONVERT sample, no overrun.
REQ-026 start outside IDLE: ignored.
REQ-027 abort=1 in any state: IDLE next cycle, res_valid=0, mod_en=0, counters cleared; abort beats start in the same cycle.
REQ-028 mod_en=1 in CLEAR, SETTLE, CONVERT, HOLD; 0 in IDLE.
REQ-029 Latency start to first res_valid = 2 cycles + (SETTLE_SAMPLES + samples per result) cic_valid strobes + 1 cycle.

Reset
REQ-030 reset_n low: state IDLE; mod_en, cic_clr, res_valid, busy, overrun = 0; ch_mux, res_ch, res_data = 0; all counters 0.
REQ-031 Reset deassertion mid-conversion: no result produced; start required to restart.

Configuration
REQ-032 With CIC_CTRL_AVG_EN defined: result = sum of 4 consecutive CONVERT samples (DATA_W+2-bit accumulator, no overflow) right-shifted by 2, truncated.
REQ-033 Without CIC_CTRL_AVG_EN: result = single CONVERT sample, unmodified; no accumulator logic.

Structure
REQ-034 Shared package cic_pkg SHALL hold the FSM state enum, CIC_DATA_W=14, CIC_SETTLE=3, AVG_LEN=4.
REQ-035 Sub-module cic_sample_cnt SHALL implement the strobe counter (load, enable, terminal-count flag) reused for SETTLE and CONVERT.

Verification
REQ-036 start, ch_sel=2, cont=0, cic_data=0x1234 every strobe, res_ready=1 -> one cic_clr pulse, 3 strobes discarded, res_data=0x1234, res_ch=2, then IDLE, mod_en=0.
REQ-037 AVG_EN, samples 100,101,102,103 after settle -> res_data=101.
REQ-038 cont=1, res_ready=0 for 600 cycles, strobe every 256 -> res_valid held, overrun=1, res_data unchanged; next start clears overrun.
REQ-039 abort asserted during SETTLE after 2 strobes -> IDLE next cycle, busy=0, no res_valid.
REQ-040 start during CONVERT with ch_sel=3 -> ignored, ch_mux unchanged.
REQ-041 reset_n low during HOLD -> all outputs 0 immediately (asynchronous), no result after release.
